apb_master_bridge: RTL and testbench

Parametrised APB master bridge between the Pep9 processor memory interface and APB peripherals.
- Processor side: valid/ready request channel plus a one-cycle response pulse.
- APB side: multi-slave PSel vector decoded from the address, wait-state support via PReady, PSlvErr reporting, and a programmable wait-state timeout.
- Replaces level-sensitive transfer detection with an explicit, fully synchronous handshake.

---
 rtl/apb_master_bridge_if.sv | 33 +++
 rtl/apb_master_bridge.sv | 96 +++++++++
 tb/tb_apb_master_bridge.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: processor request/response channel and APB master bus bundled for the bridge.
interface apb_master_bridge_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int NSLV   = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] PAddr;
    logic [NSLV-1:0]   PSel;
    logic              PEnable;
    logic              PWrite;
    logic [DATA_W-1:0] PWData;
    logic              PReady;
    logic [DATA_W-1:0] PRData;
    logic              PSlvErr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PReady, PRData, PSlvErr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, PAddr, PSel, PEnable, PWrite, PWData
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PReady, PRData, PSlvErr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, PAddr, PSel, PEnable, PWrite, PWData
    );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: Pep9 valid/ready request channel to a multi-slave APB master
// with wait states, PSlvErr reporting and an optional wait-state timeout.
module apb_master_bridge #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int NSLV    = 4,
    parameter int TIMEOUT = 15
) (
    input logic PClk,
    input logic PResetn,
    apb_master_bridge_if.master bus
);
    localparam int SW = $clog2(NSLV);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic              accept;
    logic              done;
    logic              abort;

    always_ff @(posedge PClk or negedge PResetn) begin
        if (!PResetn)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        case (state)
            IDLE: begin
                accept  = bus.req_valid;
                state_n = bus.req_valid ? SETUP : IDLE;
            end
            SETUP: begin
                cnt_n   = '0;
                state_n = ACCESS;
            end
            ACCESS: begin
                done    = bus.PReady;
                // The wait that would make the count reach TIMEOUT ends the transfer instead.
                abort   = !bus.PReady && (TIMEOUT != 0) && (cnt == CNT_LAST);
                cnt_n   = cnt + 1'b1;
                state_n = (done || abort) ? IDLE : ACCESS;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge PClk or negedge PResetn) begin
        if (!PResetn) begin
            cnt       <= '0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            cnt       <= cnt_n;
            rsp_valid <= done | abort;
            rsp_err   <= abort | (done & bus.PSlvErr);
            rsp_rdata <= (done && !pwrite) ? bus.PRData : '0;
            if (accept) begin
                paddr  <= bus.req_addr;
                pwrite <= bus.req_write;
                pwdata <= bus.req_write ? bus.req_wdata : '0;
            end
        end
    end

    // APB strobes decode from state so a reset drops them without waiting for a clock.
    assign bus.req_ready = state == IDLE;
    assign bus.PSel      = (state == IDLE) ? '0 : NSLV'(1) << paddr[ADDR_W-1 -: SW];
    assign bus.PEnable   = state == ACCESS;
    assign bus.PAddr     = paddr;
    assign bus.PWrite    = pwrite;
    assign bus.PWData    = pwdata;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_err   = rsp_err;
    assign bus.rsp_rdata = rsp_rdata;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed transfers against a response scoreboard plus APB-side phase checks.
module tb_apb_master_bridge;
    logic PClk;
    logic PResetn;
    int   passed = 0;
    int   total  = 0;

    typedef struct packed {
        logic       err;
        logic [7:0] rdata;
    } rsp_t;

    rsp_t q[$];

    apb_master_bridge_if #(.ADDR_W(16), .DATA_W(8), .NSLV(4)) b1 ();
    apb_master_bridge_if #(.ADDR_W(16), .DATA_W(8), .NSLV(4)) b0 ();

    apb_master_bridge #(.ADDR_W(16), .DATA_W(8), .NSLV(4), .TIMEOUT(15)) dut (
        .PClk(PClk), .PResetn(PResetn), .bus(b1)
    );
    apb_master_bridge #(.ADDR_W(16), .DATA_W(8), .NSLV(4), .TIMEOUT(0)) dut_nt (
        .PClk(PClk), .PResetn(PResetn), .bus(b0)
    );

    initial PClk = 1'b0;
    always #5 PClk = ~PClk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Response monitor: pops one expectation per rsp_valid pulse.
    initial begin
        rsp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge PClk);
            if (prev)
                chk("rsp_pulse_end", {b1.rsp_valid, b1.rsp_err, b1.rsp_rdata}, 0);
            if (b1.rsp_valid) begin
                chk("rsp_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("rsp_err", b1.rsp_err, e.err);
                    chk("rsp_rdata", b1.rsp_rdata, e.rdata);
                end
            end
            prev = b1.rsp_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic xfer(input logic wr, input logic [15:0] addr, input logic [7:0] wd, input int waits,
                        input logic [7:0] rd, input logic serr, input logic [3:0] sel);
        @(posedge PClk); #1;
        b1.req_write = wr;
        b1.req_addr  = addr;
        b1.req_wdata = wd;
        b1.req_valid = 1'b1;
        q.push_back('{err: serr, rdata: wr ? 8'h00 : rd});
        @(negedge PClk);
        chk("req_ready_idle", b1.req_ready, 1);
        @(posedge PClk); #1;
        b1.req_valid = 1'b0;
        b1.req_addr  = ~addr;
        b1.req_wdata = ~wd;
        @(negedge PClk);
        chk("setup_psel", b1.PSel, sel);
        chk("setup_penable", b1.PEnable, 0);
        chk("setup_req_ready", b1.req_ready, 0);
        chk("setup_pwrite", b1.PWrite, wr);
        chk("setup_pwdata", b1.PWData, wr ? wd : 8'h00);
        chk("setup_paddr", b1.PAddr, addr);
        for (int k = 0; k <= waits; k++) begin
            @(posedge PClk); #1;
            b1.PReady  = (k == waits);
            b1.PSlvErr = (k == waits) ? serr : 1'b1;
            b1.PRData  = (k == waits) ? rd : 8'hEE;
            @(negedge PClk);
            chk("access_penable", b1.PEnable, 1);
            chk("access_psel", b1.PSel, sel);
            chk("access_paddr", b1.PAddr, addr);
            chk("access_pwdata", b1.PWData, wr ? wd : 8'h00);
        end
        @(posedge PClk); #1;
        b1.PReady  = 1'b0;
        b1.PSlvErr = 1'b0;
        b1.PRData  = 8'h00;
        @(negedge PClk);
        chk("done_psel", b1.PSel, 0);
        chk("done_penable", b1.PEnable, 0);
        chk("done_paddr_hold", b1.PAddr, addr);
        chk("done_pwrite_hold", b1.PWrite, wr);
        chk("done_req_ready", b1.req_ready, 1);
    endtask

    logic        bw[3]  = '{1'b1, 1'b0, 1'b1};
    logic [15:0] ba[3]  = '{16'h0001, 16'h8002, 16'h4003};
    logic [7:0]  bd[3]  = '{8'h11, 8'h00, 8'h22};
    logic [7:0]  br[3]  = '{8'h66, 8'h77, 8'h88};
    logic [3:0]  bs[3]  = '{4'b0001, 4'b0100, 4'b0010};

    initial begin
        PResetn = 1'b0;
        {b1.req_valid, b1.req_write, b1.req_addr, b1.req_wdata, b1.PReady, b1.PRData, b1.PSlvErr} = '0;
        {b0.req_valid, b0.req_write, b0.req_addr, b0.req_wdata, b0.PReady, b0.PRData, b0.PSlvErr} = '0;
        repeat (3) @(posedge PClk);
        #1 PResetn = 1'b1;
        @(negedge PClk);
        chk("reset_req_ready", b1.req_ready, 1);
        chk("reset_outputs", {b1.PSel, b1.PEnable, b1.PWrite, b1.PWData, b1.PAddr}, 0);
        chk("reset_rsp", {b1.rsp_valid, b1.rsp_err, b1.rsp_rdata}, 0);
        chk("reset_nt_ready", b0.req_ready, 1);

        xfer(1'b1, 16'h4012, 8'hA5, 0, 8'h77, 1'b0, 4'b0010);
        xfer(1'b0, 16'hC003, 8'h00, 3, 8'h3C, 1'b0, 4'b1000);
        xfer(1'b0, 16'h8010, 8'h00, 2, 8'h99, 1'b1, 4'b0100);
        xfer(1'b0, 16'h0020, 8'h00, 2, 8'h5A, 1'b0, 4'b0001);

        // Timeout: PReady never rises
        @(posedge PClk); #1;
        b1.req_write = 1'b0;
        b1.req_addr  = 16'h2000;
        b1.req_valid = 1'b1;
        q.push_back('{err: 1'b1, rdata: 8'h00});
        @(posedge PClk); #1;
        b1.req_valid = 1'b0;
        b1.PSlvErr   = 1'b1;
        b1.PRData    = 8'h3C;
        @(negedge PClk);
        chk("to_setup_psel", b1.PSel, 4'b0001);
        for (int k = 0; k < 15; k++) begin
            @(posedge PClk);
            @(negedge PClk);
            chk("to_penable_high", b1.PEnable, 1);
        end
        @(posedge PClk);
        @(negedge PClk);
        chk("to_abort_strobes", {b1.PSel, b1.PEnable}, 0);
        chk("to_abort_rsp_valid", b1.rsp_valid, 1);
        b1.PSlvErr = 1'b0;
        b1.PRData  = 8'h00;

        // Back-to-back with req_valid held and a zero-wait slave
        @(posedge PClk); #1;
        b1.PReady    = 1'b1;
        b1.req_valid = 1'b1;
        q.push_back('{err: 1'b0, rdata: 8'h00});
        q.push_back('{err: 1'b0, rdata: 8'h77});
        q.push_back('{err: 1'b0, rdata: 8'h00});
        for (int i = 0; i < 3; i++) begin
            b1.req_write = bw[i];
            b1.req_addr  = ba[i];
            b1.req_wdata = bd[i];
            @(posedge PClk); #1;
            if (i == 2) b1.req_valid = 1'b0;
            b1.PRData = br[i];
            @(negedge PClk);
            chk("b2b_setup_psel", {b1.PSel, b1.PEnable}, {bs[i], 1'b0});
            @(posedge PClk);
            @(negedge PClk);
            chk("b2b_access", {b1.PSel, b1.PEnable}, {bs[i], 1'b1});
            @(posedge PClk);
            @(negedge PClk);
            chk("b2b_rsp_and_ready", {b1.rsp_valid, b1.req_ready, b1.PSel}, {2'b11, 4'b0000});
        end
        @(posedge PClk); #1;
        b1.PReady = 1'b0;
        b1.PRData = 8'h00;
        @(negedge PClk);
        chk("b2b_idle_after", b1.PSel, 0);

        // Reset during a wait state
        @(posedge PClk); #1;
        b1.req_write = 1'b0;
        b1.req_addr  = 16'hC000;
        b1.req_valid = 1'b1;
        @(posedge PClk); #1;
        b1.req_valid = 1'b0;
        @(posedge PClk);
        @(posedge PClk); #1;
        #2 PResetn = 1'b0;
        #1;
        chk("rst_mid_strobes", {b1.PSel, b1.PEnable, b1.rsp_valid}, 0);
        chk("rst_mid_req_ready", b1.req_ready, 1);
        @(posedge PClk); #1;
        PResetn = 1'b1;
        xfer(1'b0, 16'hC000, 8'h00, 1, 8'hC3, 1'b0, 4'b1000);

        // TIMEOUT = 0: no abort however long PReady stays low
        @(posedge PClk); #1;
        b0.req_write = 1'b0;
        b0.req_addr  = 16'h4000;
        b0.req_valid = 1'b1;
        @(posedge PClk); #1;
        b0.req_valid = 1'b0;
        @(negedge PClk);
        chk("nt_setup_psel", b0.PSel, 4'b0010);
        for (int k = 0; k < 100; k++) begin
            @(posedge PClk);
            @(negedge PClk);
            chk("nt_waiting", {b0.PEnable, b0.rsp_valid}, 2'b10);
        end
        @(posedge PClk); #1;
        b0.PReady = 1'b1;
        b0.PRData = 8'h5A;
        @(posedge PClk); #1;
        b0.PReady = 1'b0;
        @(negedge PClk);
        chk("nt_rsp", {b0.rsp_valid, b0.rsp_err, b0.rsp_rdata}, {2'b10, 8'h5A});
        chk("nt_strobes_off", {b0.PSel, b0.PEnable}, 0);

        repeat (2) @(negedge PClk);
        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
